toggle_burst_sched: RTL and testbench
=====================================

// Module: toggle_burst_sched
// PURPOSE
//   Round-robin scheduler that shares one toggle generator between two requesters.
//   Each requester asks for a burst: N toggles at a programmable half-period, counted in clk cycles.
//   The block arbitrates between requesters, captures the winner's burst parameters and sequences the burst.
//   It drives the shared toggle line and returns a per-requester completion pulse.
// PARAMETERS
//   HP_W   8  width of half-period inputs/counter (cycles between toggle edges)
//   NT_W   8  width of toggle-count inputs/counter
// PORTS
//   clk        in   1      single clock, all logic on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   req        in   2      level request per requester; hold until done or abort
//   half_per0  in   HP_W   requester 0 half-period; sampled only in LOAD
//   half_per1  in   HP_W   requester 1 half-period; sampled only in LOAD
//   ntog0      in   NT_W   requester 0 toggle count; sampled only in LOAD
//   ntog1      in   NT_W   requester 1 toggle count; sampled only in LOAD
//   grant      out  2      one-hot owner, asserted LOAD..DONE inclusive
//   busy       out  1      state != IDLE
//   toggle     out  1      shared toggle line (registered)
//   done       out  2      one-cycle completion pulse to owner
// BEHAVIOUR
//   Reset: state=IDLE; grant=0, busy=0, toggle=0, done=0; rr_ptr=0; counters cleared.
//   FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered.
//   IDLE: if req!=0, go to LOAD next cycle.
//     - Winner = the only active requester, else requester rr_ptr.
//     - grant asserts on entry to LOAD.
//   LOAD (1 cycle): capture hp_eff, rem and cnt from the owner's inputs.
//     - hp_eff = half_per (value 0 treated as 1).
//     - rem = ntog.
//     - cnt = hp_eff-1.
//     - rem==0 -> DONE (no toggle); else -> RUN.
//   RUN: each cycle, if cnt!=0, cnt-=1.
//     - If cnt==0: toggle<=~toggle, rem-=1, cnt<=hp_eff-1.
//     - If rem==1 at that edge, go to DONE.
//     - Net effect: first edge after hp_eff RUN cycles; RUN lasts hp_eff*ntog cycles.
//   DONE (1 cycle): done[owner]=1, toggle forced to 0.
//     - rr_ptr = ~owner (other requester gets priority).
//     - Next state IDLE; grant drops on leaving DONE.
//   Abort: owner's req low in LOAD or RUN -> IDLE next cycle.
//     - toggle<=0, grant<=0, no done pulse.
//     - rr_ptr still flips to the other requester.
//   Requester that is not the owner: its req changes are ignored until the block returns to IDLE.
//   Owner param inputs may change after LOAD without effect.
//   Back-to-back: req held after done -> IDLE 1 cycle, then re-arbitrate. Min gap 2 cycles done->next LOAD.
//   Counter widths: cnt HP_W bits, rem NT_W bits; no wrap (loaded <= max, only decremented to 0).
//   rst_n assertion mid-burst: immediate return to reset values, regardless of clk.
// TESTING
//   1. req=01, hp0=3, nt0=4 -> LOAD 1 cycle; toggle edges every 3 cycles, 4 edges (0-1-0-1-0); done[0] 12 RUN cycles after LOAD; grant=01 throughout.
//   2. req=11 from reset, hp=2, nt=1 each -> grant 01 first, done[0]; then grant 10, done[1]; then grant 01 again (round-robin alternation).
//   3. nt0=0 -> LOAD then DONE; done[0] pulses, toggle never leaves 0. hp0=0, nt0=2 -> toggle edges every cycle.
//   4. hp0=5, nt0=6; drop req[0] in 2nd RUN cycle after 1st edge -> toggle=0, grant=0 next cycle, no done; pending req[1] wins next.
//   5. rst_n low asynchronously mid-RUN (between clk edges) -> grant/busy/toggle/done all 0 immediately; after release, req=10 wins (rr_ptr=0 but only 10 active).
//   6. hp=255, nt=255 (max) -> exactly 255 edges, done after 65025 RUN cycles, no counter wrap.

Source files
------------

// File: rtl/toggle_burst_sched.sv
// ============================================================================
// Module      : toggle_burst_sched
// Description : Round-robin scheduler sharing one toggle generator between two
//               requesters; each burst is N toggles at a programmable
//               half-period, finished by a one-cycle done pulse to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_burst_sched #(
    parameter int HP_W = 8,
    parameter int NT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    input  logic [HP_W-1:0] half_per0,
    input  logic [HP_W-1:0] half_per1,
    input  logic [NT_W-1:0] ntog0,
    input  logic [NT_W-1:0] ntog1,
    output logic [1:0]      grant,
    output logic            busy,
    output logic            toggle,
    output logic [1:0]      done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [HP_W-1:0] c_hp_zero = '0;
    localparam logic [HP_W-1:0] c_hp_one  = {{(HP_W-1){1'b0}}, 1'b1};
    localparam logic [NT_W-1:0] c_nt_zero = '0;
    localparam logic [NT_W-1:0] c_nt_one  = {{(NT_W-1){1'b0}}, 1'b1};

    logic [1:0]      r_state, w_state;
    logic            r_owner, w_owner;
    logic            r_rr_ptr, w_rr_ptr;
    logic [HP_W-1:0] r_reload, w_reload;
    logic [HP_W-1:0] r_cnt, w_cnt;
    logic [NT_W-1:0] r_rem, w_rem;
    logic [1:0]      r_grant, w_grant;
    logic            r_busy, w_busy;
    logic            r_toggle, w_toggle;
    logic [1:0]      r_done, w_done;

    logic [HP_W-1:0] w_sel_hp;
    logic [HP_W-1:0] w_hp_eff;
    logic [NT_W-1:0] w_sel_nt;
    logic            w_winner;
    logic            w_owner_req;
    logic [1:0]      w_owner_oh;

    assign w_sel_hp    = r_owner ? half_per1 : half_per0;
    assign w_sel_nt    = r_owner ? ntog1 : ntog0;
    assign w_hp_eff    = (w_sel_hp == c_hp_zero) ? c_hp_one : w_sel_hp;
    assign w_owner_req = r_owner ? req[1] : req[0];
    assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;

    // A lone requester wins outright; contention is settled by the rr pointer.
    always_comb begin
        w_winner = r_rr_ptr;
        case (req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            default: w_winner = r_rr_ptr;
        endcase
    end

    always_comb begin
        w_state  = r_state;
        w_owner  = r_owner;
        w_rr_ptr = r_rr_ptr;
        w_reload = r_reload;
        w_cnt    = r_cnt;
        w_rem    = r_rem;
        w_grant  = r_grant;
        w_toggle = r_toggle;
        w_done   = 2'b00;

        case (r_state)
            c_st_idle: begin
                if (req != 2'b00) begin
                    w_state = c_st_load;
                    w_owner = w_winner;
                    w_grant = w_winner ? 2'b10 : 2'b01;
                end
            end

            c_st_load: begin
                if (!w_owner_req) begin
                    w_state  = c_st_idle;
                    w_grant  = 2'b00;
                    w_toggle = 1'b0;
                    w_rr_ptr = ~r_owner;
                end else begin
                    w_reload = w_hp_eff - c_hp_one;
                    w_cnt    = w_hp_eff - c_hp_one;
                    w_rem    = w_sel_nt;
                    if (w_sel_nt == c_nt_zero) begin
                        w_state = c_st_done;
                        w_done  = w_owner_oh;
                    end else begin
                        w_state = c_st_run;
                    end
                end
            end

            c_st_run: begin
                if (!w_owner_req) begin
                    w_state  = c_st_idle;
                    w_grant  = 2'b00;
                    w_toggle = 1'b0;
                    w_rr_ptr = ~r_owner;
                end else if (r_cnt != c_hp_zero) begin
                    w_cnt = r_cnt - c_hp_one;
                end else begin
                    // The final edge is still driven; DONE clears the line afterwards.
                    w_toggle = ~r_toggle;
                    w_rem    = r_rem - c_nt_one;
                    w_cnt    = r_reload;
                    if (r_rem == c_nt_one) begin
                        w_state = c_st_done;
                        w_done  = w_owner_oh;
                    end
                end
            end

            default: begin
                w_state  = c_st_idle;
                w_grant  = 2'b00;
                w_toggle = 1'b0;
                w_rr_ptr = ~r_owner;
            end
        endcase

        w_busy = (w_state != c_st_idle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_owner  <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_reload <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_grant  <= 2'b00;
            r_busy   <= 1'b0;
            r_toggle <= 1'b0;
            r_done   <= 2'b00;
        end else begin
            r_state  <= w_state;
            r_owner  <= w_owner;
            r_rr_ptr <= w_rr_ptr;
            r_reload <= w_reload;
            r_cnt    <= w_cnt;
            r_rem    <= w_rem;
            r_grant  <= w_grant;
            r_busy   <= w_busy;
            r_toggle <= w_toggle;
            r_done   <= w_done;
        end
    end

    assign grant  = r_grant;
    assign busy   = r_busy;
    assign toggle = r_toggle;
    assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_toggle_burst_sched.sv
// ============================================================================
// Module      : tb_toggle_burst_sched
// Description : Scoreboard bench for toggle_burst_sched; expected grant, toggle
//               and done events are queued with cycle offsets from grant rise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_burst_sched;

    localparam int HP_W = 8;
    localparam int NT_W = 8;
    localparam int c_k_gnt = 0;
    localparam int c_k_tog = 1;
    localparam int c_k_done = 2;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req;
    logic [HP_W-1:0] half_per0, half_per1;
    logic [NT_W-1:0] ntog0, ntog1;
    logic [1:0]      grant;
    logic            busy;
    logic            toggle;
    logic [1:0]      done;

    toggle_burst_sched #(.HP_W(HP_W), .NT_W(NT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .half_per0 (half_per0),
        .half_per1 (half_per1),
        .ntog0     (ntog0),
        .ntog1     (ntog1),
        .grant     (grant),
        .busy      (busy),
        .toggle    (toggle),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
        int rel;
    } evt_t;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int kind, input int val, input int rel);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        e.rel  = rel;
        exp_q.push_back(e);
    endtask

    // Pushes the events of a fully-run burst that starts with a fresh grant.
    task automatic push_burst(input int who, input int hp, input int nt);
        int hpe;
        hpe = (hp == 0) ? 1 : hp;
        push(c_k_gnt, (who == 0) ? 1 : 2, 0);
        for (int k = 1; k <= nt; k++) begin
            push(c_k_tog, k % 2, hpe * k + 1);
        end
        push(c_k_done, (who == 0) ? 1 : 2, hpe * nt + 1);
        if (nt % 2 == 1) push(c_k_tog, 0, hpe * nt + 2);
    endtask

    task automatic sb_obs(input int kind, input int val, input int rel);
        evt_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got kind=%0d val=%0d rel=%0d, expected no event",
                     kind, val, rel);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.val == val && e.rel == rel) n_pass++;
            else $display("FAIL sb_evt: got kind=%0d val=%0d rel=%0d, expected kind=%0d val=%0d rel=%0d",
                          kind, val, rel, e.kind, e.val, e.rel);
        end
    endtask

    // Monitor: turns output activity into timestamped events.
    initial begin : mon
        logic [1:0] prev_g;
        logic       prev_t;
        int         cyc;
        int         gcyc;
        prev_g = 2'b00;
        prev_t = 1'b0;
        cyc    = 0;
        gcyc   = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (grant != prev_g && grant != 2'b00) begin
                    gcyc = cyc;
                    sb_obs(c_k_gnt, int'(grant), 0);
                end
                if (toggle != prev_t) sb_obs(c_k_tog, int'(toggle), cyc - gcyc);
                if (done != 2'b00) sb_obs(c_k_done, int'(done), cyc - gcyc);
            end
            prev_g = grant;
            prev_t = toggle;
        end
    end

    task automatic wait_done(input string name, input int bound);
        int k;
        k = 0;
        while (done == 2'b00 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (done == 2'b00) begin
            n_checks++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, bound);
        end
    endtask

    task automatic wait_grant(input string name, input int bound);
        int k;
        k = 0;
        while (grant == 2'b00 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (grant == 2'b00) begin
            n_checks++;
            $display("FAIL %s_timeout: got no grant after %0d cycles, expected grant", name, bound);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        half_per0 = '0; half_per1 = '0;
        ntog0 = '0; ntog1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_toggle", int'(toggle), 0);
        chk("rst_done", int'(done), 0);

        // Basic burst: hp=3, 4 edges.
        half_per0 = 8'd3; ntog0 = 8'd4;
        push_burst(0, 3, 4);
        req = 2'b01;
        wait_done("t1", 40);
        chk("t1_done", int'(done), 1);
        chk("t1_grant", int'(grant), 1);
        chk("t1_busy", int'(busy), 1);
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_grant", int'(grant), 0);

        // Round-robin alternation under continuous contention.
        do_reset();
        half_per0 = 8'd2; ntog0 = 8'd1;
        half_per1 = 8'd2; ntog1 = 8'd1;
        push_burst(0, 2, 1);
        push_burst(1, 2, 1);
        push_burst(0, 2, 1);
        req = 2'b11;
        wait_done("t2a", 20);
        chk("t2a_done", int'(done), 1);
        @(negedge clk);
        wait_done("t2b", 20);
        chk("t2b_done", int'(done), 2);
        @(negedge clk);
        wait_done("t2c", 20);
        chk("t2c_done", int'(done), 1);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Zero toggle count, then zero half-period.
        half_per0 = 8'd3; ntog0 = 8'd0;
        push(c_k_gnt, 1, 0);
        push(c_k_done, 1, 1);
        req = 2'b01;
        wait_done("t3a", 20);
        chk("t3a_toggle", int'(toggle), 0);
        req = 2'b00;
        repeat (3) @(negedge clk);
        half_per0 = 8'd0; ntog0 = 8'd2;
        push_burst(0, 0, 2);
        req = 2'b01;
        wait_done("t3b", 20);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Abort by owner; pending requester 1 takes over.
        half_per0 = 8'd5; ntog0 = 8'd6;
        half_per1 = 8'd1; ntog1 = 8'd3;
        push(c_k_gnt, 1, 0);
        push(c_k_tog, 1, 6);
        push(c_k_tog, 0, 8);
        push_burst(1, 1, 3);
        req = 2'b01;
        wait_grant("t4", 20);
        req = 2'b11;
        repeat (7) @(negedge clk);
        req = 2'b10;
        @(negedge clk);
        chk("t4_abort_grant", int'(grant), 0);
        chk("t4_abort_toggle", int'(toggle), 0);
        chk("t4_abort_done", int'(done), 0);
        wait_done("t4", 40);
        chk("t4_done", int'(done), 2);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a run.
        half_per0 = 8'd4; ntog0 = 8'd4;
        push(c_k_gnt, 1, 0);
        push(c_k_tog, 1, 5);
        req = 2'b01;
        wait_grant("t5", 20);
        repeat (6) @(negedge clk);
        chk("t5_pre_busy", int'(busy), 1);
        chk("t5_pre_toggle", int'(toggle), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_grant", int'(grant), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_toggle", int'(toggle), 0);
        chk("t5_rst_done", int'(done), 0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        half_per1 = 8'd1; ntog1 = 8'd3;
        push_burst(1, 1, 3);
        req = 2'b10;
        wait_done("t5", 40);
        chk("t5_done", int'(done), 2);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Maximum parameters.
        half_per0 = 8'd255; ntog0 = 8'd255;
        push_burst(0, 255, 255);
        req = 2'b01;
        wait_done("t6", 70000);
        chk("t6_done", int'(done), 1);
        req = 2'b00;
        repeat (4) @(negedge clk);

        chk("sb_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
